ibex_instr_mem_responder: RTL

//  Memory-side responder for the Ibex instruction-fetch bus (req/gnt/rvalid/rdata/err).

---
 rtl/ibex_instr_mem_responder_if.sv | 13 +
 rtl/ibex_instr_mem_responder.sv | 86 ++++++++
 2 files changed

// File: rtl/ibex_instr_mem_responder_if.sv
// Ibex instruction-fetch bus: req/addr from the prefetch side, gnt/rvalid/rdata/err
// back from memory.
interface ibex_instr_mem_responder_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, addr, input gnt, rvalid, rdata, err);
  modport slave  (input req, addr, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/ibex_instr_mem_responder.sv
// Instruction memory model for the Ibex fetch bus: grants up to MAX_OUTSTANDING
// requests and returns array data in order, LATENCY cycles after each grant.
module ibex_instr_mem_responder #(
  parameter int unsigned MEM_WORDS       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned LATENCY         = 2,
  parameter int unsigned MAX_OUTSTANDING = 2,
  localparam int unsigned AW = $clog2(MEM_WORDS),
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  ibex_instr_mem_responder_if.slave    bus,
  input  logic                         stall_i,
  input  logic                         load_we_i,
  input  logic [AW-1:0]                load_addr_i,
  input  logic [31:0]                  load_wdata_i,
  output logic [CW-1:0]                outstanding_o
);

  logic [31:0]        mem [MEM_WORDS];
  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] err_q;
  logic [31:0]        data_q [LATENCY];
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [31:0]        off;
  logic               acc_err;
  logic [AW-1:0]      acc_idx;
  logic               rvalid;
  logic               unused_off_bits;

  // Offset wraps, so addresses below BASE_ADDR land far out of range and flag err.
  assign off             = bus.addr - BASE_ADDR;
  assign acc_err         = |off[31:AW+2];
  assign acc_idx         = off[AW+1:2];
  assign unused_off_bits = ^off[1:0];

  assign rvalid = valid_q[LATENCY-1];

  // A response retiring this cycle frees its slot for a same-cycle grant.
  assign bus.gnt = bus.req & ~stall_i & ~rst_i &
                   ((cnt_q - CW'(rvalid)) < CW'(MAX_OUTSTANDING));

  // NOTE: the array has no reset; its contents come from the loader, and a reset
  // would force it out of RAM into individually cleared flops.
  always_ff @(posedge clk_i) begin
    if (load_we_i) mem[load_addr_i] <= load_wdata_i;
  end

  // Reading mem here samples pre-edge contents, so a same-cycle load returns old data.
  // NOTE: sequential state uses <= so every stage sees the pre-edge value of its
  // neighbour; blocking assignments here would collapse the shift register.
  always_ff @(posedge clk_i) begin
    err_q[0]  <= acc_err;
    data_q[0] <= acc_err ? '0 : mem[acc_idx];
    for (int i = 1; i < LATENCY; i++) begin
      err_q[i]  <= err_q[i-1];
      data_q[i] <= data_q[i-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= bus.gnt;
      for (int i = 1; i < LATENCY; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  // NOTE: cnt_d is assigned on every path through the block, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q + CW'(bus.gnt) - CW'(rvalid);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign outstanding_o = cnt_q;
  assign bus.rvalid    = rvalid;
  assign bus.err       = rvalid & err_q[LATENCY-1];
  assign bus.rdata     = rvalid ? data_q[LATENCY-1] : '0;

endmodule
